// File: rtl/shift_rleft_arbiter.sv
// Round-robin arbiter sharing one rotate-left unit between Ports requesters, with a single
// registered result stage. Define SHIFT_RLEFT_ARB_STATS_EN to add per-port grant counters.
module shift_rleft_arbiter #(
  parameter  int Bits  = 64,
  parameter  int Ports = 4,
  localparam int SW    = $clog2(Bits),
  localparam int IW    = $clog2(Ports)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [Ports-1:0]      req_valid,
  output logic [Ports-1:0]      req_ready,
  input  logic [Ports*Bits-1:0] req_a,
  input  logic [Ports*SW-1:0]   req_sh,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [Bits-1:0]       res_b,
  output logic [IW-1:0]         res_id
`ifdef SHIFT_RLEFT_ARB_STATS_EN
  ,
  output logic [Ports*16-1:0]   grant_cnt
`endif
);

  logic [IW-1:0]   ptr;
  logic [IW-1:0]   cand;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_found;
  logic            can_load;
  logic            xfer;
  logic [Bits-1:0] sel_a;
  logic [SW-1:0]   sel_sh;
  logic [Bits-1:0] rot;

  // Search starts at ptr; IW-bit addition wraps modulo Ports since Ports is a power of two.
  always_comb begin
    can_load  = !res_valid || res_ready;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < Ports; i++) begin
      cand = ptr + IW'(i);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    req_ready = '0;
    if (!reset && can_load && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  assign xfer   = |(req_valid & req_ready);
  assign sel_a  = req_a[gnt_idx*Bits +: Bits];
  assign sel_sh = req_sh[gnt_idx*SW +: SW];
  // sh=0 makes the right shift a full-width shift, which yields zero and leaves sel_a intact.
  assign rot    = (sel_a << sel_sh) | (sel_a >> (Bits - int'(sel_sh)));

  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_b     <= '0;
      res_id    <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      res_valid <= 1'b1;
      res_b     <= rot;
      res_id    <= gnt_idx;
      ptr       <= gnt_idx + 1'b1;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

`ifdef SHIFT_RLEFT_ARB_STATS_EN
  logic [Ports-1:0][15:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      for (int p = 0; p < Ports; p++)
        if (req_valid[p] && req_ready[p]) cnt[p] <= cnt[p] + 16'd1;
    end
  end

  assign grant_cnt = cnt;
`endif

endmodule
